// File: rtl/sysid_check_ctrl.sv
// rtl/sysid_check_ctrl.sv - boot-time system-ID check sequencer and CPU access arbiter
// Reads ID and timestamp words, compares them to build-time constants, retries on mismatch.
module sysid_check_ctrl #(
  parameter logic [31:0] EXPECTED_ID  = 32'd0,
  parameter logic [31:0] EXPECTED_TS  = 32'd1459711255,
  parameter int          READ_LATENCY = 0,
  parameter int          MAX_RETRY    = 3,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        cpu_address,
  input  logic        cpu_read,
  output logic [31:0] cpu_readdata,
  output logic        cpu_waitrequest,
  output logic        sid_address,
  input  logic [31:0] sid_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail_id,
  output logic        fail_ts,
  output logic [3:0]  retry_cnt,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, CHECK} state_t;

  localparam logic [2:0] LAT_MAX   = 3'(READ_LATENCY);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);
  localparam state_t     RST_STATE = AUTO_START ? RD_ID : IDLE;

  state_t     state;
  logic [2:0] lat_cnt;
  logic       lat_last;

  assign lat_last = (lat_cnt == LAT_MAX);

  // The CPU owns the slave only while no check runs; its reads reuse lat_cnt for wait states.
  assign sid_address     = busy ? (state == RD_TS) : cpu_address;
  assign cpu_readdata    = busy ? 32'd0 : sid_readdata;
  assign cpu_waitrequest = busy | (cpu_read & ~lat_last);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= RST_STATE;
      busy      <= AUTO_START;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_id   <= 1'b0;
      fail_ts   <= 1'b0;
      retry_cnt <= 4'd0;
      id_value  <= 32'd0;
      ts_value  <= 32'd0;
      lat_cnt   <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RD_ID;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            retry_cnt <= 4'd0;
            lat_cnt   <= 3'd0;
          end else if (cpu_read) begin
            lat_cnt <= lat_last ? 3'd0 : lat_cnt + 3'd1;
          end
        end
        RD_ID: begin
          if (lat_last) begin
            id_value <= sid_readdata;
            lat_cnt  <= 3'd0;
            state    <= RD_TS;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        RD_TS: begin
          if (lat_last) begin
            ts_value <= sid_readdata;
            lat_cnt  <= 3'd0;
            state    <= CHECK;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        CHECK: begin
          fail_id <= (id_value != EXPECTED_ID);
          fail_ts <= (ts_value != EXPECTED_TS);
          if ((id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS)) begin
            pass  <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (retry_cnt < RETRY_MAX) begin
            retry_cnt <= retry_cnt + 4'd1;
            state     <= RD_ID;
          end else begin
            pass  <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// tb/tb_sysid_check_ctrl.sv - directed scoreboard bench for sysid_check_ctrl
module tb_sysid_check_ctrl;

  localparam logic [31:0] TS = 32'd1459711255;

  typedef struct {
    int          which;
    int          edges;
    int          busy_cyc;
    logic        pass;
    logic        fail_id;
    logic        fail_ts;
    logic [3:0]  retry;
    logic [31:0] id;
    logic [31:0] ts;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  exp_t sb[$];
  logic first_addr0;

  logic        rst_n0, start0, cpu_address0, cpu_read0;
  logic [31:0] cpu_readdata0, sid_readdata0, id_value0, ts_value0;
  logic        cpu_waitrequest0, sid_address0, busy0, done0, pass0, fail_id0, fail_ts0;
  logic [3:0]  retry_cnt0;
  logic [31:0] id_word, ts_word;

  logic        rst_n2, start2, cpu_address2, cpu_read2;
  logic [31:0] cpu_readdata2, sid_readdata2, id_value2, ts_value2;
  logic        cpu_waitrequest2, sid_address2, busy2, done2, pass2, fail_id2, fail_ts2;
  logic [3:0]  retry_cnt2;
  logic        a_d1 = 1'b0, a_d2 = 1'b0;

  assign sid_readdata0 = sid_address0 ? ts_word : id_word;

  always @(posedge clock) begin
    a_d1 <= sid_address2;
    a_d2 <= a_d1;
  end
  assign sid_readdata2 = a_d2 ? TS : 32'd0;

  sysid_check_ctrl #(.READ_LATENCY(0), .MAX_RETRY(3), .AUTO_START(1'b1)) dut0 (
    .clock(clock), .reset_n(rst_n0), .start(start0),
    .cpu_address(cpu_address0), .cpu_read(cpu_read0),
    .cpu_readdata(cpu_readdata0), .cpu_waitrequest(cpu_waitrequest0),
    .sid_address(sid_address0), .sid_readdata(sid_readdata0),
    .busy(busy0), .done(done0), .pass(pass0), .fail_id(fail_id0), .fail_ts(fail_ts0),
    .retry_cnt(retry_cnt0), .id_value(id_value0), .ts_value(ts_value0)
  );

  sysid_check_ctrl #(.READ_LATENCY(2), .MAX_RETRY(3), .AUTO_START(1'b1)) dut2 (
    .clock(clock), .reset_n(rst_n2), .start(start2),
    .cpu_address(cpu_address2), .cpu_read(cpu_read2),
    .cpu_readdata(cpu_readdata2), .cpu_waitrequest(cpu_waitrequest2),
    .sid_address(sid_address2), .sid_readdata(sid_readdata2),
    .busy(busy2), .done(done2), .pass(pass2), .fail_id(fail_id2), .fail_ts(fail_ts2),
    .retry_cnt(retry_cnt2), .id_value(id_value2), .ts_value(ts_value2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input int which, input int edges, input int bc, input logic p,
                      input logic fi, input logic ft, input logic [3:0] r,
                      input logic [31:0] id, input logic [31:0] ts);
    exp_t e;
    e.which = which; e.edges = edges; e.busy_cyc = bc; e.pass = p;
    e.fail_id = fi; e.fail_ts = ft; e.retry = r; e.id = id; e.ts = ts;
    sb.push_back(e);
  endtask

  // Runs until the targeted instance reports done with busy low, then scores against the queue head.
  task automatic run(input string tag, input int fix_at);
    exp_t e;
    int n = 0, bc = 0, viol = 0;
    logic seen = 1'b0, b, d, wr;
    logic [31:0] rd;
    check({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      start0 = 1'b0;
      start2 = 1'b0;
      n++;
      if (n == fix_at) ts_word = TS;
      if (n == 1) first_addr0 = sid_address0;
      b  = (e.which == 0) ? busy0 : busy2;
      d  = (e.which == 0) ? done0 : done2;
      wr = (e.which == 0) ? cpu_waitrequest0 : cpu_waitrequest2;
      rd = (e.which == 0) ? cpu_readdata0 : cpu_readdata2;
      if (b) begin
        bc++;
        if (!wr || rd != 32'd0) viol++;
      end
      if (d && !b) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_edges"}, n, e.edges);
    check({tag, "_busy_cycles"}, bc, e.busy_cyc);
    check({tag, "_cpu_stall"}, viol, 32'd0);
    if (e.which == 0) begin
      check({tag, "_pass"}, 32'(pass0), 32'(e.pass));
      check({tag, "_fail_id"}, 32'(fail_id0), 32'(e.fail_id));
      check({tag, "_fail_ts"}, 32'(fail_ts0), 32'(e.fail_ts));
      check({tag, "_retry"}, 32'(retry_cnt0), 32'(e.retry));
      check({tag, "_id"}, id_value0, e.id);
      check({tag, "_ts"}, ts_value0, e.ts);
    end else begin
      check({tag, "_pass"}, 32'(pass2), 32'(e.pass));
      check({tag, "_fail_id"}, 32'(fail_id2), 32'(e.fail_id));
      check({tag, "_fail_ts"}, 32'(fail_ts2), 32'(e.fail_ts));
      check({tag, "_retry"}, 32'(retry_cnt2), 32'(e.retry));
      check({tag, "_id"}, id_value2, e.id);
      check({tag, "_ts"}, ts_value2, e.ts);
    end
  endtask

  task automatic check_reset0(input string tag);
    check({tag, "_busy"}, 32'(busy0), 32'd1);
    check({tag, "_done"}, 32'(done0), 32'd0);
    check({tag, "_pass"}, 32'(pass0), 32'd0);
    check({tag, "_fails"}, {30'd0, fail_id0, fail_ts0}, 32'd0);
    check({tag, "_retry"}, 32'(retry_cnt0), 32'd0);
    check({tag, "_id"}, id_value0, 32'd0);
    check({tag, "_ts"}, ts_value0, 32'd0);
    check({tag, "_addr"}, 32'(sid_address0), 32'd0);
    check({tag, "_wait"}, 32'(cpu_waitrequest0), 32'd1);
  endtask

  initial begin
    int wcnt;
    rst_n0 = 1'b0; start0 = 1'b0; cpu_address0 = 1'b0; cpu_read0 = 1'b0;
    rst_n2 = 1'b0; start2 = 1'b0; cpu_address2 = 1'b1; cpu_read2 = 1'b0;
    id_word = 32'd0; ts_word = TS;
    repeat (2) @(negedge clock);

    // Auto-start after reset, zero latency
    check_reset0("rst");
    rst_n0 = 1'b1;
    push(0, 3, 2, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, TS);
    run("auto", 0);
    check("auto_first_addr", 32'(first_addr0), 32'd1);

    // Permanent ID mismatch exhausts all retries
    id_word = 32'h5;
    start0 = 1'b1;
    push(0, 13, 12, 1'b0, 1'b1, 1'b0, 4'd3, 32'h5, TS);
    run("id_bad", 0);
    id_word = 32'd0;

    // Wrong timestamp on the first attempt only
    ts_word = 32'hDEAD_BEEF;
    start0 = 1'b1;
    push(0, 7, 6, 1'b1, 1'b0, 1'b0, 4'd1, 32'd0, TS);
    run("ts_once", 3);

    // CPU read of addr 1 in the same cycle as start
    cpu_address0 = 1'b1; cpu_read0 = 1'b1; start0 = 1'b1;
    #1;
    check("cpu_rd_data", cpu_readdata0, TS);
    check("cpu_rd_wait", 32'(cpu_waitrequest0), 32'd0);
    check("cpu_rd_busy", 32'(busy0), 32'd0);
    push(0, 4, 3, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, TS);
    run("cpu_start", 0);
    cpu_read0 = 1'b0; cpu_address0 = 1'b0;

    // Reset pulse while reading the timestamp
    start0 = 1'b1;
    @(negedge clock); start0 = 1'b0;
    @(negedge clock);
    check("mid_rd_ts_addr", 32'(sid_address0), 32'd1);
    rst_n0 = 1'b0;
    @(negedge clock);
    check_reset0("mid_rst");
    rst_n0 = 1'b1;
    push(0, 3, 2, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, TS);
    run("after_rst", 0);

    // Latency-2 instance with a CPU read held during the check
    cpu_read2 = 1'b1;
    rst_n2 = 1'b1;
    push(2, 7, 6, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, TS);
    run("lat2", 0);
    wcnt = 0;
    for (int i = 0; i < 10 && cpu_waitrequest2; i++) begin
      wcnt++;
      @(negedge clock);
    end
    check("lat2_cpu_wait_cycles", wcnt, 32'd2);
    check("lat2_cpu_data", cpu_readdata2, TS);
    cpu_read2 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
